uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, FIFO-buffered UART transmitter with configurable data width, stop bits, bit period and optional parity. It generalises the fixed idle-high UART stimulus that drives `isp_uart_rx` / `user_uart_rx` on `soc_top`. Benches use it to stream ISP and user bytes into the SoC, and RTL reuses it as the transmit half of SoC UART peripherals. A producer pushes bytes through a valid/ready port; the block serialises them back-to-back, LSB first.

## Interface
Parameters:
- `CLK_DIV`, default 868: clocks per bit (115200 baud at 100 MHz). Legal range 2..65535.
- `DATA_BITS`, default 8: data bits per frame. Legal range 5..8.
- `STOP_BITS`, default 1: stop bits per frame. Legal values 1 or 2.
- `FIFO_AW`, default 4: FIFO depth is 2^FIFO_AW entries. Legal range 1..8.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wvalid`  in  1: producer offers `wdata`.
- `wready`  out  1: FIFO can accept; equals !full.
- `wdata`  in  DATA_BITS: byte to send.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high while a frame is on the line or the FIFO is non-empty.
- `count`  out  FIFO_AW+1: current FIFO occupancy, 0..2^FIFO_AW.

## Operation
- Push: on an edge where `wvalid && wready`, `wdata` is written at the write pointer and `count` increments.
- Full handling: `wready` = (count != 2^FIFO_AW). When full, no push occurs, even if a pop happens on the same edge.
- Pointers are FIFO_AW bits wide and wrap naturally. `count` is a separate register updated as +1 on push, -1 on pop, unchanged on both or neither.
- FSM states and `tx` level:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=shift[0]; the register shifts right once per bit.
  - PARITY: only with macro.
  - STOP: `tx`=1.
- A bit-period counter (16 bit) counts 0..CLK_DIV-1. The state advances when it reaches CLK_DIV-1, then the counter resets to 0.
- IDLE → START: when count>0. The same edge pops the head into the shift register and loads bit index 0.
- START → DATA after one bit period.
- DATA → (PARITY or STOP) after DATA_BITS periods.
- STOP lasts STOP_BITS periods. At its end:
  - if count>0, pop and go directly to START (no idle gap);
  - otherwise go to IDLE.
- `busy` = (state != IDLE) || (count != 0), combinational.
- `tx` is driven from a register; it never glitches.

## Timing
- Reset values: `tx`=1, `wready`=1, `busy`=0, `count`=0, state IDLE, pointers 0, bit counter 0. Reset discards FIFO contents.
- Reset mid-frame: `tx`=1 from the edge where `rst` is sampled high. The partial frame is abandoned, not completed.
- Latency: push at edge N gives `count`=1 after N. The pop occurs at edge N+1 and `tx` falls after edge N+1. Idle-to-start-bit latency is therefore 2 clocks.
- Frame length: CLK_DIV × (1 + DATA_BITS + P + STOP_BITS) clocks, where P=1 with parity, else 0.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit clock.
- Simultaneous push and pop (not full): `count` unchanged, both pointers advance.
- Push into an empty FIFO on the same edge as STOP-end with count=0: FSM goes to IDLE. The byte is popped on the next edge, giving one extra idle-high clock.
- `wdata` bits above DATA_BITS do not exist; data is LSB first.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds the PARITY state of one bit period between DATA and STOP.
  - `tx` = even parity, the XOR of the DATA_BITS data bits, computed at pop time.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state, no parity logic; DATA goes straight to STOP.
  - Frame length formula uses P=0.

## Test plan
- Reset check: assert `rst` for 3 clocks, including once mid-frame → `tx`=1, `busy`=0, `count`=0, `wready`=1 on the first clock after reset. No further start bit until a new push.
- Single byte, CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, no parity: push 0xA5 → `tx` low 2 clocks after push. Serial pattern, 4 clocks each: 0, 1,0,1,0,0,1,0,1, 1. `busy` drops after 40 clocks of frame.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive clocks → `count` peaks at 2 (one popped). Three contiguous 40-clock frames with no idle gap. `busy` deasserts exactly once.
- Full/wrap: FIFO_AW=2, hold `wvalid` with 0x10..0x17 while the line is slow (CLK_DIV=100) → `wready` low once `count`=4. Bytes 0x10..0x17 emerge in order with pointer wrap; none lost or duplicated.
- Simultaneous push/pop at full: make a pop and a `wvalid` coincide while count=4 → no push that edge, `count` goes 4→3, the word is accepted next clock.
- Parity build with `UART_TX_PARITY_EN`, DATA_BITS=7, STOP_BITS=2: push 0x07 → parity bit 1, frame = 4×(1+7+1+2)=44 clocks. Push 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: bytes pushed over valid/ready are sent LSB first, back to back.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 tx,
  output logic                 busy,
  output logic [FIFO_AW:0]     count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [2:0]           state;
  logic [15:0]          bit_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  logic push;
  logic pop;
  logic bit_end;
  logic stop_end;

  assign wready   = (count != FULL_COUNT);
  assign push     = wvalid && wready;
  assign bit_end  = (bit_cnt == 16'(CLK_DIV - 1));
  assign stop_end = (state == S_STOP) && bit_end && (bit_idx == 4'(STOP_BITS - 1));
  // A new frame starts from idle, or straight out of the last stop bit with no gap.
  assign pop      = ((state == S_IDLE) || stop_end) && (count != '0);
  assign busy     = (state != S_IDLE) || (count != '0);

  // NOTE: the storage array has no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      bit_cnt <= ((state == S_IDLE) || bit_end) ? 16'd0 : bit_cnt + 16'd1;
      if (pop) begin
        state   <= S_START;
        shift   <= mem[rd_ptr];
        bit_idx <= '0;
        tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^mem[rd_ptr];
`endif
      end else begin
        case (state)
          S_IDLE: tx <= 1'b1;
          S_START: begin
            if (bit_end) begin
              state <= S_DATA;
              tx    <= shift[0];
            end
          end
          S_DATA: begin
            if (bit_end) begin
              if (bit_idx == 4'(DATA_BITS - 1)) begin
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                state   <= S_PARITY;
                tx      <= parity_bit;
`else
                state   <= S_STOP;
                tx      <= 1'b1;
`endif
              end else begin
                bit_idx <= bit_idx + 4'd1;
                shift   <= shift >> 1;
                tx      <= shift[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (bit_end) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (stop_end) begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end else if (bit_end) begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
          default: begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model, serial decoder,
// vector table and hand-written corner sequences (reset, back-to-back, full/wrap).
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int D = 7;
  localparam int S = 2;
  localparam int P = 1;
`else
  localparam int D = 8;
  localparam int S = 1;
  localparam int P = 0;
`endif
  localparam int CLK_DIV = 4;
  localparam int AW      = 2;
  localparam int DEPTH   = 1 << AW;
  localparam int FB      = 1 + D + P + S;
  localparam int FL      = CLK_DIV * FB;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          wvalid = 1'b0;
  logic [D-1:0]  wdata  = '0;
  logic          wready;
  logic          tx;
  logic          busy;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_DIV  (CLK_DIV),
    .DATA_BITS(D),
    .STOP_BITS(S),
    .FIFO_AW  (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wvalid(wvalid),
    .wready(wready),
    .wdata (wdata),
    .tx    (tx),
    .busy  (busy),
    .count (count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the frame currently on the line, indexed by clock.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = '0;
  bit         rx_abort = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    logic [7:0] mask;
    mask = 8'hFF >> (8 - D);
    if (k == 0) return 1'b0;
    if (k <= D) return b[k-1];
    if (P == 1 && k == D + 1) return ^(b & mask);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit end_frame, can_pop, do_push;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      rx_abort = 1'b1;
    end else begin
      end_frame = m_active && (m_pos == FL - 1);
      can_pop   = (!m_active || end_frame) && (m_q.size() > 0);
      do_push   = wvalid && (m_q.size() < DEPTH);
      if (can_pop) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else if (end_frame) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else if (m_active) begin
        m_pos++;
      end
      if (do_push) m_q.push_back(8'(wdata));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", tx, m_active ? frame_bit(m_cur, m_pos / CLK_DIV) : 1'b1);
      check("busy", busy, m_active || (m_q.size() != 0));
      check("count", count, m_q.size());
      check("wready", wready, m_q.size() != DEPTH);
    end
  end

  // Serial decoder: recovers bytes from tx by sampling mid-bit.
  logic [7:0] rx_q[$];
  bit         rx_active = 1'b0;
  int         rx_cnt    = 0;
  int         rx_k      = 0;
  logic [7:0] rx_byte   = '0;
  logic       rx_prev   = 1'b1;

  always @(negedge clk) begin
    if (rx_abort) begin
      rx_active = 1'b0;
      rx_abort  = 1'b0;
    end else if (chk_en) begin
      if (!rx_active) begin
        if (rx_prev === 1'b1 && tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          rx_byte   = '0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CLK_DIV == CLK_DIV / 2) begin
          rx_k = rx_cnt / CLK_DIV;
          if (rx_k >= 1 && rx_k <= D) begin
            rx_byte[rx_k-1] = tx;
          end else if (rx_k == 1 + D + P) begin
            check("rx_stop", tx, 1);
            check("rx_byte", rx_byte, m_cur);
            rx_q.push_back(rx_byte);
            rx_active = 1'b0;
          end
        end
      end
    end
    rx_prev = tx;
  end

  typedef struct {
    logic [7:0]  data;
    logic [11:0] line;  // bit k = k-th bit on the wire (start first)
  } vec_t;

  vec_t vecs[4];

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pat[3];
    logic [7:0] mask;
    int peak, falls, busy_n, idx, lows;
    bit prev_b, r, pre_full_pop, sim_done, sim_next, saw_full;

    mask = 8'hFF >> (8 - D);
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h07, 12'b0_11_1_0000111_0};
    vecs[1] = '{8'h03, 12'b0_11_0_0000011_0};
    vecs[2] = '{8'h55, 12'b0_11_0_1010101_0};
    vecs[3] = '{8'h7F, 12'b0_11_1_1111111_0};
`else
    vecs[0] = '{8'hA5, 12'b00_1_10100101_0};
    vecs[1] = '{8'h00, 12'b00_1_00000000_0};
    vecs[2] = '{8'hFF, 12'b00_1_11111111_0};
    vecs[3] = '{8'h3C, 12'b00_1_00111100_0};
`endif

    // Power-on reset for 3 clocks.
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_count", count, 0);
    check("reset_wready", wready, 1);

    // Single-frame vectors: latency, bit pattern, busy release.
    for (int i = 0; i < 4; i++) begin
      wait_idle(4 * FL);
      wvalid = 1'b1;
      wdata  = vecs[i].data[D-1:0];
      @(negedge clk);
      wvalid = 1'b0;
      check($sformatf("vec%0d_lat_tx_high", i), tx, 1);
      check($sformatf("vec%0d_count1", i), count, 1);
      @(negedge clk);
      check($sformatf("vec%0d_start_low", i), tx, 0);
      repeat (CLK_DIV / 2) @(negedge clk);
      for (int k = 0; k < FB; k++) begin
        check($sformatf("vec%0d_bit%0d", i, k), tx, vecs[i].line[k]);
        if (k < FB - 1) repeat (CLK_DIV) @(negedge clk);
      end
      repeat (CLK_DIV - 1 - CLK_DIV / 2) @(negedge clk);
      check($sformatf("vec%0d_busy_last", i), busy, 1);
      @(negedge clk);
      check($sformatf("vec%0d_busy_end", i), busy, 0);
      check($sformatf("vec%0d_tx_idle", i), tx, 1);
    end

    // Back-to-back: three pushes on consecutive clocks.
    wait_idle(4 * FL);
    rx_q.delete();
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
    peak = 0; falls = 0; busy_n = 0; prev_b = 1'b0;
    for (int i = 0; i < 3 * FL + 20; i++) begin
      if (i < 3) begin
        wvalid = 1'b1;
        wdata  = pat[i][D-1:0];
      end else begin
        wvalid = 1'b0;
      end
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
      if (busy) busy_n++;
      if (prev_b && !busy) falls++;
      prev_b = busy;
    end
    check("b2b_count_peak", peak, 2);
    check("b2b_busy_falls", falls, 1);
    check("b2b_busy_cycles", busy_n, 3 * FL + 1);
    check("b2b_rx_n", rx_q.size(), 3);
    for (int j = 0; j < 3 && j < rx_q.size(); j++)
      check($sformatf("b2b_rx%0d", j), rx_q[j], pat[j] & mask);

    // Full / wrap with a pop coinciding with a held wvalid at count=4.
    wait_idle(4 * FL);
    rx_q.delete();
    idx = 0; sim_done = 1'b0; sim_next = 1'b0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 5000 && idx < 8; cyc++) begin
      r = wready;
      if (!r) saw_full = 1'b1;
      pre_full_pop = (count == 3'(DEPTH)) && m_active && (m_pos == FL - 1) && (m_q.size() > 0);
      wvalid = 1'b1;
      wdata  = D'(8'h10 + idx);
      @(negedge clk);
      if (r) idx++;
      if (pre_full_pop && !sim_done) begin
        check("full_pop_count", count, DEPTH - 1);
        check("full_pop_wready", wready, 1);
        sim_done = 1'b1;
        sim_next = 1'b1;
      end else if (sim_next) begin
        check("full_refill_count", count, DEPTH);
        sim_next = 1'b0;
      end
    end
    wvalid = 1'b0;
    check("full_all_accepted", idx, 8);
    check("full_saw_wready_low", saw_full, 1);
    check("full_sim_pushpop_seen", sim_done, 1);
    wait_idle(10 * FL);
    check("full_rx_n", rx_q.size(), 8);
    for (int j = 0; j < 8 && j < rx_q.size(); j++)
      check($sformatf("full_rx%0d", j), rx_q[j], 8'h10 + j);

    // Reset mid-frame with bytes still queued.
    wait_idle(4 * FL);
    for (int i = 0; i < 3; i++) begin
      wvalid = 1'b1;
      wdata  = D'(8'h5A ^ (i * 8'h33));
      @(negedge clk);
    end
    wvalid = 1'b0;
    repeat (CLK_DIV * 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", tx, 1);
    check("rst_mid_count", count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_after_tx", tx, 1);
    check("rst_mid_after_busy", busy, 0);
    check("rst_mid_after_count", count, 0);
    check("rst_mid_after_wready", wready, 1);
    lows = 0;
    repeat (3 * FL) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rst_no_restart", lows, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      wvalid = ($urandom_range(0, 3) == 0);
      wdata  = D'($urandom);
      @(negedge clk);
    end
    wvalid = 1'b0;
    wait_idle((DEPTH + 2) * FL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
